// File: rtl/seq_alu_issuer_pkg.sv
// Shared types for the sequential ALU issuer: opcodes, operand/result widths,
// issuer FSM state encoding and the packed command layout held in the FIFO.
package seq_alu_issuer_pkg;

    localparam int unsigned OPERAND_W = 4;
    localparam int unsigned RESULT_W  = 5;
    localparam int unsigned CMD_W     = 2 + 2 * OPERAND_W;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpAnd = 2'd2,
        OpOr  = 2'd3
    } opcode_t;

    typedef logic [1:0] issuer_state_t;

    localparam issuer_state_t StIdle  = 2'd0;
    localparam issuer_state_t StIssue = 2'd1;
    localparam issuer_state_t StWait  = 2'd2;
    localparam issuer_state_t StResp  = 2'd3;

    typedef struct packed {
        opcode_t                opcode;
        logic [OPERAND_W-1:0]   a;
        logic [OPERAND_W-1:0]   b;
    } cmd_t;

endpackage

// File: rtl/seq_alu_cmd_fifo.sv
// In-order command FIFO; depth must be a power of two so pointers wrap naturally.
module seq_alu_cmd_fifo
    import seq_alu_issuer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CMD_W-1:0] push_data,
    input  logic             pop,
    output logic [CMD_W-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == CntW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/seq_alu_issuer.sv
// Issues queued commands one at a time to an external registered ALU and
// holds each result until the consumer takes it.
module seq_alu_issuer
    import seq_alu_issuer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_opcode,
    input  logic [OPERAND_W-1:0] in_a,
    input  logic [OPERAND_W-1:0] in_b,
    output logic                 alu_en,
    output logic [1:0]           alu_opcode,
    output logic [OPERAND_W-1:0] alu_a,
    output logic [OPERAND_W-1:0] alu_b,
    input  logic [RESULT_W-1:0]  alu_c,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RESULT_W-1:0]  res_data,
    output logic [1:0]           res_opcode
);

    issuer_state_t        state_q, state_d;
    logic                 fifo_full, fifo_empty, fifo_pop, push_acc;
    logic [CMD_W-1:0]     head_raw;
    cmd_t                 head;
    cmd_t                 in_cmd;
    opcode_t              alu_op_q;
    logic [OPERAND_W-1:0] alu_a_q, alu_b_q;
    logic [RESULT_W-1:0]  res_data_q;
    opcode_t              res_op_q;

    assign in_cmd   = '{opcode: opcode_t'(in_opcode), a: in_a, b: in_b};
    assign head     = cmd_t'(head_raw);
    assign in_ready = !fifo_full;
    assign push_acc = in_valid && in_ready;
    assign fifo_pop = (state_q == StIssue);

    seq_alu_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The FIFO head drives the ALU only during ISSUE; otherwise the last issued command is held.
    assign alu_en     = (state_q == StIssue);
    assign alu_opcode = alu_en ? head.opcode : alu_op_q;
    assign alu_a      = alu_en ? head.a      : alu_a_q;
    assign alu_b      = alu_en ? head.b      : alu_b_q;
    assign res_valid  = (state_q == StResp);
    assign res_data   = res_data_q;
    assign res_opcode = res_op_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!fifo_empty) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  state_d = StResp;
            default: begin
                // A command pushed this very cycle counts as pending work.
                if (res_ready) state_d = (!fifo_empty || push_acc) ? StIssue : StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            alu_op_q   <= OpAdd;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            res_data_q <= '0;
            res_op_q   <= OpAdd;
        end else begin
            state_q <= state_d;
            if (state_q == StIssue) begin
                alu_op_q <= head.opcode;
                alu_a_q  <= head.a;
                alu_b_q  <= head.b;
            end
            if (state_q == StWait) begin
                res_data_q <= alu_c;
                res_op_q   <= alu_op_q;
            end
        end
    end

endmodule

// File: doc/seq_alu_issuer.md
SEQ_ALU_ISSUER -- requirements
Module: seq_alu_issuer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  command present.
REQ-005 in_ready  output  1  command accepted when in_valid&&in_ready.
REQ-006 in_opcode  input  2  opcode_t (ADD, SUB, AND, OR).
REQ-007 in_a, in_b  input  4 each  operands.
REQ-008 alu_en  output  1  one-cycle issue strobe to ALU.
REQ-009 alu_opcode  output  2; alu_a, alu_b  output  4 each  operation driven to ALU.
REQ-010 alu_c  input  5  ALU registered result.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 res_data  output  5; res_opcode  output  2  captured result and its opcode.

Function
REQ-014 Accepted commands SHALL be stored in order in a FIFO of FIFO_DEPTH entries; in_ready = not full.
REQ-015 When full, in_ready SHALL be 0 even if a pop occurs that cycle; no push on full.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE -> ISSUE when FIFO non-empty; otherwise stay IDLE.
REQ-019 ISSUE: alu_en=1 for exactly one cycle with FIFO head on alu_opcode/alu_a/alu_b; head popped; -> WAIT.
REQ-020 WAIT: alu_en=0; alu_c sampled at end of cycle into res_data, head opcode into res_opcode; -> RESP.
REQ-021 RESP: res_valid=1, res_data/res_opcode stable until res_ready; on res_ready -> ISSUE if FIFO non-empty (after this cycle's push), else IDLE.
REQ-022 alu_en SHALL be 0 in all states except ISSUE, so the ALU holds its output.
REQ-023 alu_opcode/alu_a/alu_b SHALL hold last issued values outside ISSUE (0 after reset).
REQ-024 Latency: pop in ISSUE at cycle N -> res_valid at N+2; peak throughput one result per 3 cycles with res_ready held 1.
REQ-025 Block SHALL perform no arithmetic; res_data equals alu_c bit-for-bit (overflow/wrap is ALU behaviour).
REQ-026 Push and FSM pop in the same cycle SHALL both take effect; occupancy unchanged.

Reset
REQ-027 While rst=1 at a clock edge: FIFO emptied, state IDLE, in_ready=1 on the following cycle, alu_en=0, res_valid=0, res_data=0, res_opcode=ADD, alu_opcode=ADD, alu_a=0, alu_b=0.
REQ-028 Reset mid-operation (ISSUE/WAIT/RESP) SHALL discard in-flight command and pending result without emitting res_valid.
REQ-029 alu_c SHALL not be assumed zero after reset; it is only sampled in WAIT.

Structure
REQ-030 opcode_t SHALL come from the existing shared SEQ_ALU_PACKAGE; add issuer_state_t, OPERAND_W=4, RESULT_W=5 there.
REQ-031 FIFO SHALL be a sub-module seq_alu_cmd_fifo (push/pop/full/empty/data); FSM and result register in the top.

Verification
REQ-032 Reset: hold rst=1 two cycles mid-RESP -> res_valid=0, alu_en=0, in_ready=1, FIFO empty next cycle.
REQ-033 Single ADD A=4'd9 B=4'd8 with reference ALU attached -> alu_en pulse 1 cycle, res_valid 2 cycles later, res_data=5'd17, res_opcode=ADD.
REQ-034 Back-to-back SUB 3-5, AND 12&10, OR 5|2, res_ready=1 -> results in order 5'd30, 5'd8, 5'd7, one every 3 cycles.
REQ-035 Fill: push 5 commands with res_ready=0 -> in_ready=0 after 4th stored (one popped to ISSUE permits 5th); no command lost or duplicated.
REQ-036 Backpressure: res_ready=0 for 10 cycles in RESP -> res_valid, res_data stable; alu_en stays 0; on release next ISSUE follows.
REQ-037 Simultaneous push and pop with FIFO at 3 entries -> occupancy stays 3; ordering preserved across pointer wrap over 20 random commands.
